// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the NOP injected into the IF/ID registers on empty or flush,
// the default fetch-entry layout {inst, pc, compressed, pred_dest},
// and small constant helpers used to size pointers and storage words.
// No ports (package).
package if_pkg;

  localparam int XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Default entry layout for XLEN = 32; the queue derives its own
  // XLEN-wide version with the same field order.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        compressed;
    logic [31:0] pred_dest;
  } fetch_entry_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Bit width of one stored fetch entry.
  function automatic int entry_width(input int xlen);
    return 3 * xlen + 1;
  endfunction

endpackage

// File: rtl/if_fq_storage.sv
// Register file holding the buffered fetch entries of the queue.
// One synchronous write port, one asynchronous read port so the head
// entry is visible in the same cycle it is popped.
// Ports:
//   clk        rising-edge clock
//   wr_en_i    write enable
//   wr_ptr_i   write address
//   wr_data_i  entry to write
//   rd_ptr_i   read address
//   rd_data_o  entry at rd_ptr_i (combinational)
module if_fq_storage import if_pkg::*; #(
  parameter int WIDTH = entry_width(XLEN_DEFAULT),
  parameter int DEPTH = 4,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents need no reset: occupancy tracking decides which words
  // are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the fetch front end and decode.
// Buffers up to DEPTH fetched instructions with their PC, compressed flag
// and predicted destination, and owns the IF/ID pipeline registers. When
// the buffer is empty and decode is not stalled, a push goes straight to
// the pipeline registers so the queue adds no latency.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               drop all buffered and incoming instructions
//   stall               decode stall, hold pipeline registers
//   push_*              fetch-side handshake and instruction payload
//   *_ppl               IF/ID pipeline registers (valid_ppl=0 is a bubble)
//   count               buffered entries, excluding the pipeline register
//   almost_full         count >= AFULL_TH
module if_fetch_queue import if_pkg::*; #(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               DEPTH    = 4,
  parameter int               AFULL_TH = 3,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(if_pkg::NOP_INST)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [XLEN-1:0]        push_inst,
  input  logic [XLEN-1:0]        push_pc,
  input  logic                   push_compressed,
  input  logic [XLEN-1:0]        push_pred_dest,
  output logic [XLEN-1:0]        inst_ppl,
  output logic [XLEN-1:0]        pc_ppl,
  output logic                   compressed_ppl,
  output logic [XLEN-1:0]        pred_dest_ppl,
  output logic                   valid_ppl,
  output logic [clog2(DEPTH):0]  count,
  output logic                   almost_full
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = entry_width(XLEN);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            compressed;
    logic [XLEN-1:0] pred_dest;
  } entry_t;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  entry_t           ppl_q, ppl_d;
  logic             valid_q, valid_d;

  entry_t           push_entry;
  entry_t           head_entry;
  logic [ENT_W-1:0] head_raw;

  logic full, empty, accept, pop, bypass, enq;

  assign push_entry = '{inst: push_inst, pc: push_pc,
                        compressed: push_compressed, pred_dest: push_pred_dest};

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Handshake depends only on registered occupancy; a full queue refuses
  // a push even when it pops in the same cycle.
  assign push_ready  = !full;
  assign almost_full = (count_q >= AFULL_C);

  assign accept = push_valid & push_ready & !flush;
  assign pop    = !stall & !flush & !empty;
  assign bypass = accept & empty & !stall;
  assign enq    = accept & !bypass;

  if_fq_storage #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk       (clk),
    .wr_en_i   (enq),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (push_entry),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (head_raw)
  );

  assign head_entry = entry_t'(head_raw);

  // Occupancy and pointers. Flush clears the buffer even while stalled.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // IF/ID registers: stall beats flush here, unlike the buffer above.
  always_comb begin
    ppl_d   = ppl_q;
    valid_d = valid_q;
    if (stall) begin
      ppl_d   = ppl_q;
      valid_d = valid_q;
    end else if (flush) begin
      ppl_d.inst       = NOP_INST;
      ppl_d.compressed = 1'b0;
      ppl_d.pc         = push_pc;
      ppl_d.pred_dest  = push_pred_dest;
      valid_d          = 1'b0;
    end else if (pop) begin
      ppl_d   = head_entry;
      valid_d = 1'b1;
    end else if (bypass) begin
      ppl_d   = push_entry;
      valid_d = 1'b1;
    end else begin
      // Bubble keeps the last PC/prediction for debug visibility.
      ppl_d.inst       = NOP_INST;
      ppl_d.compressed = 1'b0;
      valid_d          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ppl_q    <= '{inst: NOP_INST, pc: '0, compressed: 1'b0, pred_dest: '0};
      valid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ppl_q    <= ppl_d;
      valid_q  <= valid_d;
    end
  end

  assign inst_ppl       = ppl_q.inst;
  assign pc_ppl         = ppl_q.pc;
  assign compressed_ppl = ppl_q.compressed;
  assign pred_dest_ppl  = ppl_q.pred_dest;
  assign valid_ppl      = valid_q;
  assign count          = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue. A queue-based reference model
// tracks the buffered instructions and the IF/ID register contents; the
// DUT is compared against it after every clock edge.
module tb_if_fetch_queue;

  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    logic [31:0] pd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, stall, push_valid, push_compressed;
  logic [31:0] push_inst, push_pc, push_pred_dest;
  logic        push_ready, compressed_ppl, valid_ppl, almost_full;
  logic [31:0] inst_ppl, pc_ppl, pred_dest_ppl;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t        mq[$];
  ent_t        mppl;
  logic        mvalid;

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_inst       (push_inst),
    .push_pc         (push_pc),
    .push_compressed (push_compressed),
    .push_pred_dest  (push_pred_dest),
    .inst_ppl        (inst_ppl),
    .pc_ppl          (pc_ppl),
    .compressed_ppl  (compressed_ppl),
    .pred_dest_ppl   (pred_dest_ppl),
    .valid_ppl       (valid_ppl),
    .count           (count),
    .almost_full     (almost_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the reference model, from the inputs presented at the edge.
  task automatic modelStep();
    ent_t nw;
    logic acc;
    nw = '{inst: push_inst, pc: push_pc, comp: push_compressed, pd: push_pred_dest};
    if (rst) begin
      mq.delete();
      mppl   = '{inst: NOP, pc: 32'h0, comp: 1'b0, pd: 32'h0};
      mvalid = 1'b0;
    end else begin
      acc = push_valid && (mq.size() < DEPTH) && !flush;
      if (stall) begin
        if (flush) mq.delete();
        else if (acc) mq.push_back(nw);
      end else if (flush) begin
        mq.delete();
        mppl   = '{inst: NOP, pc: push_pc, comp: 1'b0, pd: push_pred_dest};
        mvalid = 1'b0;
      end else if (mq.size() > 0) begin
        mppl   = mq.pop_front();
        mvalid = 1'b1;
        if (acc) mq.push_back(nw);
      end else if (acc) begin
        mppl   = nw;
        mvalid = 1'b1;
      end else begin
        mppl.inst = NOP;
        mppl.comp = 1'b0;
        mvalid    = 1'b0;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("inst_ppl",       inst_ppl,              mppl.inst);
    checkOutput("pc_ppl",         pc_ppl,                mppl.pc);
    checkOutput("compressed_ppl", 32'(compressed_ppl),   32'(mppl.comp));
    checkOutput("pred_dest_ppl",  pred_dest_ppl,         mppl.pd);
    checkOutput("valid_ppl",      32'(valid_ppl),        32'(mvalid));
    checkOutput("count",          32'(count),            32'(mq.size()));
    checkOutput("push_ready",     32'(push_ready),       32'(mq.size() < DEPTH));
    checkOutput("almost_full",    32'(almost_full),      32'(mq.size() >= AFULL_TH));
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic s, input logic v,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic c, input logic [31:0] pd);
    rst = r; flush = f; stall = s; push_valid = v;
    push_inst = inst; push_pc = pc; push_compressed = c; push_pred_dest = pd;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  initial begin
    logic [31:0] pc;
    logic        c;
    mppl   = '{inst: NOP, pc: 32'h0, comp: 1'b0, pd: 32'h0};
    mvalid = 1'b0;

    $display("[TB] reset with push_valid held");
    applyStimulus(1, 0, 0, 1, 32'h1111_1111, 32'h40, 0, 32'h44);
    applyStimulus(1, 0, 0, 1, 32'h1111_1111, 32'h40, 0, 32'h44);
    checkOutput("reset_inst_nop", inst_ppl, 32'h0000_0013);

    $display("[TB] bypass into empty queue");
    applyStimulus(0, 0, 0, 1, 32'h0050_0093, 32'h100, 0, 32'h104);
    checkOutput("bypass_inst", inst_ppl, 32'h0050_0093);
    checkOutput("bypass_count", 32'(count), 32'd0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    $display("[TB] fill under stall");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 1, 1, 32'h00A0_0000 + 32'(i), 32'(4 * i), 0, 32'(4 * i + 4));
    checkOutput("fill_count_full", 32'(count), 32'd4);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 0, 0, 1, 32'h00A0_0004, 32'h10, 0, 32'h14);
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    $display("[TB] wrap with simultaneous push and pop");
    pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 1, 32'h00B0_0000 + pc, pc, 0, pc + 4);
      pc = pc + 4;
    end
    for (int i = 0; i < 12; i++) begin
      c = 1'($urandom_range(0, 1));
      applyStimulus(0, 0, 0, 1, 32'h00B0_0000 + pc, pc, c, pc + (c ? 32'd2 : 32'd4));
      pc = pc + (c ? 32'd2 : 32'd4);
    end
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    $display("[TB] flush with concurrent push");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 1, 32'h00C0_0000 + 32'(i), 32'h300 + 32'(4 * i), 0, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'hDEAD_BEEF, 32'h800, 0, 32'h804);
    checkOutput("flush_count", 32'(count), 32'd0);
    applyStimulus(0, 0, 0, 1, 32'h00D0_0013, 32'h900, 1, 32'h902);
    checkOutput("post_flush_bypass", inst_ppl, 32'h00D0_0013);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    $display("[TB] flush during stall");
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 0, 1, 1, 32'h00E0_0000 + 32'(i), 32'h500 + 32'(4 * i), 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'hBAD0_0000, 32'hA00, 0, 32'hA04);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("bubble_after_stall_flush", 32'(valid_ppl), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) != 0),
                    $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction fetch queue between the fetch front end (realigner/ICACHE plus branch predictor) and the IF/ID pipeline registers. It buffers up to DEPTH fetched instructions, each carrying its PC, compressed flag and predicted destination, so ICACHE latency is decoupled from ID stalls. It owns the IF/ID pipeline registers, inserts NOPs when empty or flushed, and bypasses the storage when empty, giving zero added latency.

Parameters:
XLEN, 32, width of instruction, PC and predicted destination.
DEPTH, 4, number of storage entries; power of two, at least 2.
AFULL_TH, 3, count at or above which almost_full asserts; 1 to DEPTH.
NOP_INST, 32'h00000013, instruction injected on empty or flush (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  kill all buffered and incoming instructions (branch correction)
stall  in  1  ID stall; hold the pipeline registers
push_valid  in  1  fetch presents a valid instruction
push_ready  out  1  queue can accept; equals !full
push_inst  in  XLEN  aligned (possibly compressed) instruction
push_pc  in  XLEN  PC of push_inst
push_compressed  in  1  push_inst is 16-bit
push_pred_dest  in  XLEN  predicted next PC
inst_ppl  out  XLEN  IF/ID instruction register
pc_ppl  out  XLEN  IF/ID PC register
compressed_ppl  out  1  IF/ID compressed flag
pred_dest_ppl  out  XLEN  IF/ID predicted destination
valid_ppl  out  1  IF/ID holds a real instruction (0 for NOP bubble)
count  out  log2(DEPTH)+1  current storage occupancy (excludes the pipeline register)
almost_full  out  1  count >= AFULL_TH; fetch throttle hint

Behaviour:
- Reset (rst=1 at an edge): count=0, read/write pointers=0, inst_ppl=NOP_INST, pc_ppl=0, compressed_ppl=0, pred_dest_ppl=0, valid_ppl=0. push_ready=1 after reset. Reset overrides every other input.
- Storage: circular buffer of DEPTH entries {inst, pc, compressed, pred_dest}. Pointers are log2(DEPTH) bits and wrap naturally. full = (count==DEPTH), empty = (count==0).
- push_ready is derived only from registered count, with no combinational path from stall or flush. A full queue refuses a push even in a cycle when it pops.
- accept = push_valid & push_ready & !flush.
- pop = !stall & !flush & !empty. Head entry loads into the *_ppl registers with valid_ppl=1, and rd_ptr increments.
- bypass = accept & empty & !stall. Push data loads directly into the *_ppl registers with valid_ppl=1. Storage is not written. Latency from push to ppl is 1 cycle.
- enq = accept & !bypass. Entry is written at wr_ptr, and wr_ptr increments. This covers the non-empty case and the empty-with-stall case.
- count_next = count + enq - pop. Push and pop in the same cycle leave count unchanged.
- Pipeline registers, in priority order:
  - stall=1: hold all *_ppl values.
  - flush=1: load NOP_INST, compressed 0, valid 0; pc_ppl and pred_dest_ppl take push_pc and push_pred_dest.
  - pop: load the head entry.
  - bypass: load the push data.
  - otherwise: NOP bubble, valid_ppl=0, compressed_ppl=0, pc/pred_dest hold.
- flush: count=0 and both pointers=0 at the next edge, regardless of stall. A concurrent push is dropped.
- Note: stall has priority over flush for the *_ppl registers only. The storage is still cleared.
- Order is strictly FIFO. No entry is duplicated or lost across pointer wrap.
- almost_full is combinational from registered count.

Decomposition:
- Shared package (if_pkg): NOP_INST constant; fetch-entry struct/typedef {inst, pc, compressed, pred_dest} of width 3*XLEN+1; clog2 helper.
- One natural sub-module: if_fq_storage, the DEPTH x entry register file with write port (wr_en, wr_ptr, data) and asynchronous read at rd_ptr. Control, counters and the pipeline registers stay in if_fetch_queue.

Test Plan:
- Reset: hold rst 2 cycles with push_valid=1 → inst_ppl=0x00000013, valid_ppl=0, count=0, push_ready=1. No push is accepted during reset.
- Bypass: empty queue, push inst=0x00500093 pc=0x100, stall=0 → next cycle inst_ppl=0x00500093, pc_ppl=0x100, valid_ppl=1, count stays 0.
- Fill under stall: stall=1, push 5 instructions at pc 0x0,0x4,0x8,0xC,0x10 → first 4 accepted, count=4, almost_full=1 from count 3, push_ready=0 on the 5th. Release stall → ppl shows pc 0x0,0x4,0x8,0xC on consecutive cycles, then the 5th after it is re-offered.
- Wrap-around with simultaneous push/pop: 12 cycles of continuous push with count=2 steady → output PC sequence strictly increasing by 4 (compressed=0) / 2 (compressed=1), count constant.
- Flush: count=3, assert flush with push_valid=1 → next cycle count=0, inst_ppl=NOP, valid_ppl=0. The pushed instruction never appears. A push on the following cycle bypasses with 1-cycle latency.
- Flush during stall: stall=1, flush=1, count=2 → *_ppl held unchanged, count=0 next cycle. After stall drops, a bubble (valid_ppl=0) follows unless a push arrives.
